// File: rtl/game_state_ctrl_pkg.sv
// Shared types and constants for the game supervisor: state encoding, screen
// geometry, default game tuning and the speed-divider rule.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PLAYING   = 2'd1,
      HIT       = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   localparam int unsigned H_RES = 640;
   localparam int unsigned V_RES = 480;

   localparam int unsigned LIVES_DEF      = 3;
   localparam int unsigned INVULN_DEF     = 60;
   localparam int unsigned SCORE_MAX_DEF  = 99;
   localparam int unsigned LEVEL_STEP_DEF = 10;
   localparam int unsigned DIV_START_DEF  = 500000;
   localparam int unsigned DIV_STEP_DEF   = 50000;
   localparam int unsigned DIV_MIN_DEF    = 100000;

   // The floor is tested against the decrement, so the subtraction can never wrap.
   function automatic logic [31:0] calc_divider(input logic [6:0]  score,
                                                input int unsigned level_step,
                                                input int unsigned div_start,
                                                input int unsigned div_step,
                                                input int unsigned div_min);
      logic [31:0] level;
      logic [31:0] dec;
      level = 32'(score) / level_step;
      dec   = level * div_step;
      if (dec >= div_start - div_min)
         return div_min;
      else
         return div_start - dec;
   endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Signal bundle between the renderer/VGA side and the game supervisor.
interface game_state_ctrl_if;
   logic        start_n;
   logic        vsync;
   logic        player_drawing;
   logic        obstacle_drawing;
   logic        obstacle_passed;
   logic        playing;
   logic        game_over;
   logic        invulnerable;
   logic [2:0]  lives;
   logic [6:0]  score;
   logic [6:0]  max_score;
   logic [31:0] speed_divider;

   modport master (
      output start_n, vsync, player_drawing, obstacle_drawing, obstacle_passed,
      input  playing, game_over, invulnerable, lives, score, max_score, speed_divider
   );

   modport slave (
      input  start_n, vsync, player_drawing, obstacle_drawing, obstacle_passed,
      output playing, game_over, invulnerable, lives, score, max_score, speed_divider
   );
endinterface

// File: rtl/game_state_ctrl_edge_sync.sv
// Two-flop synchroniser for an asynchronous active-low key, producing a
// single-cycle pulse on each press (synchronised 1->0 transition).
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic pulse
);
   logic meta;
   logic sync;
   logic sync_d;

   // Flops come out of reset as "key released" so no press is seen at startup.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= 1'b1;
         sync   <= 1'b1;
         sync_d <= 1'b1;
      end else begin
         meta   <= async_in;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign pulse = sync_d & ~sync;
endmodule

// File: rtl/game_state_ctrl.sv
// Game supervisor: per-frame collision check, lives/invulnerability FSM,
// score and max score, and the game-speed divider.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   IDLE      | waiting for the first start press after reset
//   PLAYING   | game running, collisions charged once per frame
//   HIT       | just hit, collisions ignored for INVULN_FRAMES
//   GAME_OVER | lives exhausted, max score latched, awaiting start
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int unsigned LIVES         = LIVES_DEF,
   parameter int unsigned INVULN_FRAMES = INVULN_DEF,
   parameter int unsigned SCORE_MAX     = SCORE_MAX_DEF,
   parameter int unsigned LEVEL_STEP    = LEVEL_STEP_DEF,
   parameter int unsigned DIV_START     = DIV_START_DEF,
   parameter int unsigned DIV_STEP      = DIV_STEP_DEF,
   parameter int unsigned DIV_MIN       = DIV_MIN_DEF
) (
   input logic              CLOCK_50,
   input logic              reset,
   game_state_ctrl_if.slave bus
);

   state_t      state;
   logic [2:0]  lives_q;
   logic [6:0]  score_q;
   logic [6:0]  max_q;
   logic [7:0]  invuln_cnt;
   logic        hit_seen;
   logic        vs_prev;
   logic        playing_q;
   logic        game_over_q;
   logic        invuln_q;
   logic [31:0] divider_q;

   logic        start_pulse;
   logic        frame_tick;
   logic        overlap;
   logic        in_game;
   logic [6:0]  score_inc;

   edge_sync u_start_sync (
      .clk      (CLOCK_50),
      .rst      (reset),
      .async_in (bus.start_n),
      .pulse    (start_pulse)
   );

   // vsync is generated in this clock domain, so a single register suffices.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)
         vs_prev <= 1'b0;
      else
         vs_prev <= bus.vsync;
   end

   assign frame_tick = vs_prev & ~bus.vsync;
   assign overlap    = bus.player_drawing & bus.obstacle_drawing;
   assign in_game    = (state == PLAYING) || (state == HIT);

   always_comb begin
      score_inc = score_q;
      if (bus.obstacle_passed && in_game && (score_q < 7'(SCORE_MAX)))
         score_inc = score_q + 7'd1;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         lives_q     <= 3'(LIVES);
         score_q     <= 7'd0;
         max_q       <= 7'd0;
         invuln_cnt  <= 8'd0;
         hit_seen    <= 1'b0;
         playing_q   <= 1'b0;
         game_over_q <= 1'b0;
         invuln_q    <= 1'b0;
      end else begin
         // An overlap on the tick cycle itself belongs to the new frame.
         if (frame_tick)
            hit_seen <= (state == PLAYING) && overlap;
         else if ((state == PLAYING) && overlap)
            hit_seen <= 1'b1;

         case (state)
            IDLE: begin
               if (start_pulse) begin
                  state     <= PLAYING;
                  score_q   <= 7'd0;
                  lives_q   <= 3'(LIVES);
                  hit_seen  <= 1'b0;
                  playing_q <= 1'b1;
               end
            end
            PLAYING: begin
               score_q <= score_inc;
               if (frame_tick && hit_seen) begin
                  lives_q <= lives_q - 3'd1;
                  if (lives_q == 3'd1) begin
                     state       <= GAME_OVER;
                     playing_q   <= 1'b0;
                     game_over_q <= 1'b1;
                  end else begin
                     state      <= HIT;
                     invuln_cnt <= 8'(INVULN_FRAMES);
                     invuln_q   <= 1'b1;
                  end
               end
            end
            HIT: begin
               score_q <= score_inc;
               if (frame_tick) begin
                  invuln_cnt <= invuln_cnt - 8'd1;
                  if (invuln_cnt == 8'd1) begin
                     state    <= PLAYING;
                     invuln_q <= 1'b0;
                  end
               end
            end
            GAME_OVER: begin
               // Score is frozen here, so re-evaluating every cycle only matters on entry.
               if (score_q > max_q)
                  max_q <= score_q;
               if (start_pulse) begin
                  state       <= PLAYING;
                  score_q     <= 7'd0;
                  lives_q     <= 3'(LIVES);
                  hit_seen    <= 1'b0;
                  game_over_q <= 1'b0;
                  playing_q   <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)
         divider_q <= DIV_START;
      else
         divider_q <= calc_divider(score_q, LEVEL_STEP, DIV_START, DIV_STEP, DIV_MIN);
   end

   assign bus.playing       = playing_q;
   assign bus.game_over     = game_over_q;
   assign bus.invulnerable  = invuln_q;
   assign bus.lives         = lives_q;
   assign bus.score         = score_q;
   assign bus.max_score     = max_q;
   assign bus.speed_divider = divider_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: behavioural game model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_game_state_ctrl;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   game_state_ctrl_if bus ();

   game_state_ctrl dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model: modes 0 idle, 1 playing, 2 hit, 3 game over.
   int m_mode, m_lives, m_score, m_max, m_inv, m_div;
   bit m_hit, m_pend, m_vs, k1, k2, k3;

   always @(posedge clk or posedge reset) begin : model
      bit pulse, tick, ov, was_play, charged;
      int lvl;
      if (reset) begin
         m_mode = 0; m_lives = 3; m_score = 0; m_max = 0; m_inv = 0;
         m_div = 500000; m_hit = 0; m_pend = 0; m_vs = 0;
         k1 = 1; k2 = 1; k3 = 1;
      end else begin
         pulse = k3 && !k2;
         k3 = k2; k2 = k1; k1 = bus.start_n;
         tick = m_vs && !bus.vsync;
         m_vs = bus.vsync;
         ov = bus.player_drawing && bus.obstacle_drawing;
         was_play = (m_mode == 1);
         charged = tick && m_hit;
         lvl = m_score / 10;
         m_div = 500000 - lvl * 50000;
         if (m_div < 100000) m_div = 100000;
         if (m_pend) begin
            if (m_score > m_max) m_max = m_score;
            m_pend = 0;
         end
         if ((m_mode == 1 || m_mode == 2) && bus.obstacle_passed && m_score < 99)
            m_score = m_score + 1;
         if (tick) m_hit = was_play && ov;
         else if (was_play && ov) m_hit = 1;
         case (m_mode)
            0, 3: if (pulse) begin
               m_mode = 1; m_score = 0; m_lives = 3; m_hit = 0;
            end
            1: if (charged) begin
               m_lives = m_lives - 1;
               if (m_lives == 0) begin m_mode = 3; m_pend = 1; end
               else begin m_mode = 2; m_inv = 60; end
            end
            2: if (tick) begin
               m_inv = m_inv - 1;
               if (m_inv == 0) m_mode = 1;
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin : compare
      logic [51:0] exp_v, act_v;
      if (!reset) begin
         exp_v = {(m_mode == 1 || m_mode == 2), (m_mode == 3), (m_mode == 2),
                  3'(m_lives), 7'(m_score), 7'(m_max), 32'(m_div)};
         act_v = {bus.playing, bus.game_over, bus.invulnerable, bus.lives,
                  bus.score, bus.max_score, bus.speed_divider};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_cmp t=%0t dut=%h model=%h", $time, act_v, exp_v);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input bit ov);
      bus.vsync = 1'b0;
      step(); step();
      bus.vsync = 1'b1;
      step();
      if (ov) begin
         bus.player_drawing = 1'b1; bus.obstacle_drawing = 1'b1;
         step();
         bus.player_drawing = 1'b0; bus.obstacle_drawing = 1'b0;
      end
      step(); step();
   endtask

   task automatic ov_pulse();
      bus.player_drawing = 1'b1; bus.obstacle_drawing = 1'b1;
      step();
      bus.player_drawing = 1'b0; bus.obstacle_drawing = 1'b0;
      step();
   endtask

   task automatic pass();
      bus.obstacle_passed = 1'b1;
      step();
      bus.obstacle_passed = 1'b0;
      step();
   endtask

   task automatic start_press();
      bus.start_n = 1'b0;
      repeat (10) step();
      bus.start_n = 1'b1;
      repeat (5) step();
   endtask

   task automatic hit_and_recover();
      ov_pulse();
      frame(1'b0);
      repeat (60) frame(1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      int rises;
      logic prev;
      bus.start_n = 1'b1; bus.vsync = 1'b1; bus.player_drawing = 1'b0;
      bus.obstacle_drawing = 1'b0; bus.obstacle_passed = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("rst_playing", 32'(bus.playing), 0);
      chk("rst_lives", 32'(bus.lives), 3);
      chk("rst_score", 32'(bus.score), 0);
      chk("rst_div", bus.speed_divider, 500000);

      // Held key: exactly one start.
      rises = 0;
      prev = bus.playing;
      bus.start_n = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (bus.playing && !prev) rises++;
         prev = bus.playing;
      end
      bus.start_n = 1'b1;
      repeat (5) step();
      chk("start_once", 32'(rises), 1);
      chk("start_playing", 32'(bus.playing), 1);
      chk("start_lives", 32'(bus.lives), 3);
      chk("start_div", bus.speed_divider, 500000);

      // First hit, then 60 frames of immunity.
      ov_pulse();
      frame(1'b0);
      chk("hit_lives", 32'(bus.lives), 2);
      chk("hit_invuln", 32'(bus.invulnerable), 1);
      repeat (59) frame(1'b1);
      chk("immune_lives", 32'(bus.lives), 2);
      chk("immune_invuln", 32'(bus.invulnerable), 1);
      frame(1'b0);
      chk("recover_invuln", 32'(bus.invulnerable), 0);
      chk("recover_playing", 32'(bus.playing), 1);
      chk("recover_lives", 32'(bus.lives), 2);

      // Score and speed levels.
      repeat (25) pass();
      chk("score25", 32'(bus.score), 25);
      chk("div25", bus.speed_divider, 400000);
      repeat (95) pass();
      chk("score_sat", 32'(bus.score), 99);
      chk("div_floor", bus.speed_divider, 100000);

      // Game over at 12, then a worse game keeps the best.
      do_reset();
      start_press();
      repeat (12) pass();
      hit_and_recover();
      hit_and_recover();
      ov_pulse();
      frame(1'b0);
      chk("go12_over", 32'(bus.game_over), 1);
      chk("go12_max", 32'(bus.max_score), 12);
      start_press();
      chk("restart_score", 32'(bus.score), 0);
      chk("restart_lives", 32'(bus.lives), 3);
      repeat (5) pass();
      hit_and_recover();
      hit_and_recover();
      ov_pulse();
      frame(1'b0);
      chk("go5_score", 32'(bus.score), 5);
      chk("go5_max", 32'(bus.max_score), 12);

      // Pass coincident with the fatal tick at score 7.
      do_reset();
      start_press();
      repeat (7) pass();
      hit_and_recover();
      hit_and_recover();
      ov_pulse();
      bus.vsync = 1'b0;
      bus.obstacle_passed = 1'b1;
      step();
      bus.obstacle_passed = 1'b0;
      chk("fatal_over", 32'(bus.game_over), 1);
      chk("fatal_score", 32'(bus.score), 8);
      chk("fatal_max_pre", 32'(bus.max_score), 0);
      step();
      chk("fatal_max", 32'(bus.max_score), 8);
      bus.vsync = 1'b1;
      repeat (3) step();

      // Asynchronous reset in the middle of HIT.
      do_reset();
      start_press();
      repeat (30) pass();
      hit_and_recover();
      hit_and_recover();
      ov_pulse();
      frame(1'b0);
      chk("max30", 32'(bus.max_score), 30);
      start_press();
      ov_pulse();
      frame(1'b0);
      chk("midhit_invuln", 32'(bus.invulnerable), 1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_playing", 32'(bus.playing), 0);
      chk("arst_invuln", 32'(bus.invulnerable), 0);
      chk("arst_lives", 32'(bus.lives), 3);
      chk("arst_max", 32'(bus.max_score), 0);
      chk("arst_div", bus.speed_divider, 500000);
      step();
      reset = 1'b0;
      repeat (5) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Game supervisor that sits directly downstream of the sprite renderers.
- Consumes the per-pixel player/obstacle drawing flags, the VGA vertical sync and a start key.
- Detects player/obstacle overlap once per frame and runs the game FSM with lives and invulnerability.
- Keeps score and max score, and drives the game-speed divider used by the slow-clock generator and the obstacle controller.

Parameters:
- LIVES, 3: lives granted at game start (1..7).
- INVULN_FRAMES, 60: frames of collision immunity after a hit (1..255).
- SCORE_MAX, 99: score saturation value (must fit 7 bits).
- LEVEL_STEP, 10: points per speed level.
- DIV_START, 500000: speed divider at level 0.
- DIV_STEP, 50000: divider decrement per level.
- DIV_MIN, 100000: divider floor.

Ports:
- CLOCK_50  in  1: system clock; all logic on its rising edge.
- reset  in  1: asynchronous, active-high; clears all state.
- start_n  in  1: start key, active-low, asynchronous to CLOCK_50.
- vsync  in  1: VGA_VS, active-low, generated in the CLOCK_50 domain.
- player_drawing  in  1: player sprite opaque at the current pixel.
- obstacle_drawing  in  1: obstacle sprite opaque at the current pixel.
- obstacle_passed  in  1: one-cycle pulse when an obstacle leaves the screen unhit.
- playing  out  1: high in PLAYING or HIT.
- game_over  out  1: high in GAME_OVER.
- invulnerable  out  1: high in HIT (used for sprite blink).
- lives  out  3: remaining lives.
- score  out  7: current score.
- max_score  out  7: best score since reset.
- speed_divider  out  32: half-period count for the slow game clock.

Behaviour:
- Reset values:
  - State IDLE.
  - playing=0, game_over=0, invulnerable=0.
  - lives=LIVES, score=0, max_score=0.
  - speed_divider=DIV_START.
- start_n input conditioning:
  - Two-flop synchroniser.
  - A start press is a 1->0 transition of the synchronised signal, giving a one-cycle start_pulse.
  - Holding the key produces no further pulses.
- Frame boundary:
  - frame_tick is a one-cycle pulse on the first cycle vsync is sampled low after having been high. This is a single-register edge detector with no synchroniser, since vsync is in the same domain.
- Overlap detection:
  - hit_seen is set on any cycle where player_drawing && obstacle_drawing.
  - It is cleared on frame_tick; a coincident overlap on that same cycle belongs to the new frame and sets hit_seen again.
- FSM (registered, evaluated each cycle):
  - IDLE: start_pulse -> PLAYING; score=0, lives=LIVES.
  - PLAYING:
    - On frame_tick with hit_seen: lives-1.
    - If the result is 0 -> GAME_OVER, else -> HIT with invuln_cnt=INVULN_FRAMES.
  - HIT:
    - Overlap is ignored.
    - invuln_cnt decrements on each frame_tick; when it reaches 0 -> PLAYING.
    - hit_seen is cleared on that same tick, so a carried-over overlap is not charged.
  - GAME_OVER:
    - On entry, max_score = max(max_score, score); the update is visible one cycle after the transition.
    - start_pulse -> PLAYING; score=0, lives=LIVES, hit_seen cleared.
  - start_pulse in PLAYING or HIT is ignored.
- Score:
  - Increments by 1 on obstacle_passed only in PLAYING or HIT.
  - Saturates at SCORE_MAX.
  - obstacle_passed in IDLE or GAME_OVER is ignored.
  - obstacle_passed and a fatal frame_tick on the same cycle: the increment is applied first, and max_score uses the incremented score.
- Speed:
  - level = score / LEVEL_STEP (integer).
  - speed_divider = max(DIV_MIN, DIV_START - level*DIV_STEP).
  - Computed in 32-bit unsigned arithmetic, with the floor applied before any underflow can occur.
  - Registered; updates one cycle after score changes.
  - Returns to DIV_START when score is cleared at start.
- Reset mid-game:
  - Immediate asynchronous return to reset values, including max_score.
  - The synchroniser flops reset to 1 (key released).

Decomposition:
- Shared package game_pkg:
  - State encoding: IDLE=0, PLAYING=1, HIT=2, GAME_OVER=3.
  - Screen constants (640x480).
  - Default LIVES, SCORE_MAX and divider constants shared with the top level.
- One sub-module: edge_sync (2-flop synchroniser plus falling-edge pulse). Used for start_n; the vsync edge detector is inline.

Test Plan:
- Reset, then a 1->0 pulse on start_n held for 1000 cycles -> exactly one transition to PLAYING; playing=1, lives=3, score=0, speed_divider=500000.
- Overlap asserted for 1 cycle in frame N -> at the next vsync falling edge lives=2 and invulnerable=1. Overlap in every frame for the next 60 frames -> lives stays 2. After 60 ticks -> PLAYING.
- 25 obstacle_passed pulses -> score=25, speed_divider=400000. After 120 total pulses -> score=99, speed_divider=100000 (floor).
- Three hits separated by invulnerability windows, after score 12 -> game_over=1, max_score=12. Restart, score 5, die -> max_score stays 12.
- obstacle_passed on the same cycle as the fatal frame_tick at score 7 -> max_score=8.
- reset pulsed mid-HIT with max_score=30 -> all outputs at reset values immediately (asynchronously), including max_score=0 and speed_divider=500000.
